// File: rtl/decrypt_unit.sv
// decrypt_unit: receive-side byte cipher, XOR with rotating key then inverse bit permutation,
// two-stage pipeline into an output FIFO. Define DECRYPT_KEY_EN for run-time key ports k1/k2/k3.
`ifndef XOR_KEY1
`define XOR_KEY1 8'h3C
`endif
`ifndef XOR_KEY2
`define XOR_KEY2 8'h77
`endif
`ifndef XOR_KEY3
`define XOR_KEY3 8'hA5
`endif
`ifndef PERM_0
`define PERM_0 3'd3
`endif
`ifndef PERM_1
`define PERM_1 3'd6
`endif
`ifndef PERM_2
`define PERM_2 3'd0
`endif
`ifndef PERM_3
`define PERM_3 3'd5
`endif
`ifndef PERM_4
`define PERM_4 3'd1
`endif
`ifndef PERM_5
`define PERM_5 3'd7
`endif
`ifndef PERM_6
`define PERM_6 3'd2
`endif
`ifndef PERM_7
`define PERM_7 3'd4
`endif

module decrypt_unit #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       en,
   input  logic       key_sync,
`ifdef DECRYPT_KEY_EN
   input  logic [7:0] k1,
   input  logic [7:0] k2,
   input  logic [7:0] k3,
`endif
   output logic       in_rdy,
   output logic [7:0] dout,
   output logic       v,
   input  logic       rdy
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [2:0] PERM [8] = '{3'(`PERM_0), 3'(`PERM_1), 3'(`PERM_2), 3'(`PERM_3),
                                      3'(`PERM_4), 3'(`PERM_5), 3'(`PERM_6), 3'(`PERM_7)};

   logic [7:0] key1_w, key2_w, key3_w;
`ifdef DECRYPT_KEY_EN
   assign key1_w = k1;
   assign key2_w = k2;
   assign key3_w = k3;
`else
   assign key1_w = `XOR_KEY1;
   assign key2_w = `XOR_KEY2;
   assign key3_w = `XOR_KEY3;
`endif

   logic [1:0]    phase_q, phase_d, use_phase;
   logic          s1_valid_q, s1_valid_d;
   logic [7:0]    s1_din_q, s1_din_d;
   logic [7:0]    s1_key_q, s1_key_d;
   logic [7:0]    key_sel;
   logic          accept;

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    dout_q, dout_d;
   logic [7:0]    x, plain;
   logic          push, pop;
   logic [CW:0]   occ;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // Occupancy counts the stage-1 byte so it is always guaranteed a FIFO slot.
   assign occ    = {1'b0, count_q} + {{CW{1'b0}}, s1_valid_q};
   assign in_rdy = occ < DEPTH_W;
   assign v      = (count_q != '0);
   assign dout   = dout_q;

   always_comb begin
      phase_d    = phase_q;
      s1_valid_d = 1'b0;
      s1_din_d   = s1_din_q;
      s1_key_d   = s1_key_q;
      accept     = en && in_rdy;
      use_phase  = key_sync ? 2'd0 : phase_q;
      case (use_phase)
         2'd0:    key_sel = key3_w;
         2'd1:    key_sel = key1_w;
         default: key_sel = key2_w;
      endcase
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_din_d   = din;
         s1_key_d   = key_sel;
         phase_d    = (use_phase == 2'd2) ? 2'd0 : use_phase + 2'd1;
      end
   end

   always_comb begin
      x     = s1_din_q ^ s1_key_q;
      plain = '0;
      for (int i = 0; i < 8; i++) plain[PERM[i]] = x[i];
      push     = s1_valid_q;
      pop      = v && rdy;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = plain;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // Registered head: keeps the last byte visible once the FIFO runs empty.
      dout_d = (count_d != '0) ? mem_d[rd_ptr_d] : dout_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q    <= 2'd0;
         s1_valid_q <= 1'b0;
         s1_din_q   <= 8'h00;
         s1_key_q   <= 8'h00;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         dout_q     <= 8'h00;
      end else begin
         phase_q    <= phase_d;
         s1_valid_q <= s1_valid_d;
         s1_din_q   <= s1_din_d;
         s1_key_q   <= s1_key_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         dout_q     <= dout_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_decrypt_unit.sv
// Bench for decrypt_unit: reference queue model checked every cycle, plus literal vectors.
`ifndef XOR_KEY1
`define XOR_KEY1 8'h3C
`endif
`ifndef XOR_KEY2
`define XOR_KEY2 8'h77
`endif
`ifndef XOR_KEY3
`define XOR_KEY3 8'hA5
`endif
`ifndef PERM_0
`define PERM_0 3'd3
`endif
`ifndef PERM_1
`define PERM_1 3'd6
`endif
`ifndef PERM_2
`define PERM_2 3'd0
`endif
`ifndef PERM_3
`define PERM_3 3'd5
`endif
`ifndef PERM_4
`define PERM_4 3'd1
`endif
`ifndef PERM_5
`define PERM_5 3'd7
`endif
`ifndef PERM_6
`define PERM_6 3'd2
`endif
`ifndef PERM_7
`define PERM_7 3'd4
`endif

module tb_decrypt_unit;
   localparam int DEPTH = 4;

   logic       clk, rst, en, key_sync, rdy, in_rdy, v;
   logic [7:0] din, dout;
   logic [7:0] k1 = `XOR_KEY1;
   logic [7:0] k2 = `XOR_KEY2;
   logic [7:0] k3 = `XOR_KEY3;

   decrypt_unit #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .din(din), .en(en), .key_sync(key_sync),
`ifdef DECRYPT_KEY_EN
      .k1(k1), .k2(k2), .k3(k3),
`endif
      .in_rdy(in_rdy), .dout(dout), .v(v), .rdy(rdy));

   int checks = 0;
   int errors = 0;
   int perm [8] = '{`PERM_0, `PERM_1, `PERM_2, `PERM_3, `PERM_4, `PERM_5, `PERM_6, `PERM_7};

   logic [7:0] q [$];
   logic [7:0] pend;
   bit         pend_vld;
   int         phase;
   logic [7:0] last_dout;
   logic [7:0] got_q [$];
   int         got_cyc [$];
   int         cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] key_of(input int ph);
      case (ph)
         0:       return k3;
         1:       return k1;
         default: return k2;
      endcase
   endfunction

   function automatic logic [7:0] dec(input logic [7:0] c, input logic [7:0] key);
      logic [7:0] x, p;
      x = c ^ key;
      p = '0;
      for (int i = 0; i < 8; i++) p[perm[i]] = x[i];
      return p;
   endfunction

   function automatic logic [7:0] enc(input logic [7:0] p, input logic [7:0] key);
      logic [7:0] x;
      for (int i = 0; i < 8; i++) x[i] = p[perm[i]];
      return x ^ key;
   endfunction

   // Model: pend is the byte accepted at the last edge; q is the FIFO contents.
   always @(negedge clk) begin
      bit exp_rdy;
      int up;
      cyc++;
      if (!rst) begin
         chk("rst_v", v, 0);
         chk("rst_dout", dout, 8'h00);
         chk("rst_in_rdy", in_rdy, 1);
         q.delete();
         pend_vld  = 0;
         phase     = 0;
         last_dout = 8'h00;
      end else begin
         exp_rdy = (q.size() + int'(pend_vld)) < DEPTH;
         chk("in_rdy", in_rdy, exp_rdy);
         chk("v", v, q.size() != 0);
         chk("dout", dout, (q.size() != 0) ? q[0] : last_dout);
         if (q.size() != 0) last_dout = q[0];
         if (q.size() != 0 && rdy) begin
            got_q.push_back(dout);
            got_cyc.push_back(cyc);
            void'(q.pop_front());
         end
         if (pend_vld) q.push_back(pend);
         pend_vld = 0;
         if (en && exp_rdy) begin
            up       = key_sync ? 0 : phase;
            pend     = dec(din, key_of(up));
            pend_vld = 1;
            phase    = (up + 1) % 3;
         end
      end
   end

   task automatic send(input logic [7:0] b, input logic sync);
      din = b; en = 1'b1; key_sync = sync;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_rdy) begin
            @(posedge clk); #1;
            key_sync = 1'b0;
            return;
         end
      end
      errors++;
      checks++;
      $display("FAIL send_timeout actual=in_rdy_low required=accept byte %0h", b);
      en = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int acc;
      rst = 1'b0; en = 1'b0; key_sync = 1'b0; rdy = 1'b1; din = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_v", v, 0);
      end
      @(posedge clk); #1;

      // Literal vectors with keys k1=3C k2=77 k3=A5.
      got_q.delete(); got_cyc.delete();
      send(8'hA5, 1'b1);
      chk("first_v_early", v, 0);
      send(8'h3C, 1'b0);
      chk("first_v_2edges", v, 1);
      send(8'h77, 1'b0);
      send(8'h5A, 1'b0);
      en = 1'b0;
      repeat (5) @(posedge clk); #1;
      chk("vec_count", got_q.size(), 4);
      if (got_q.size() == 4) begin
         chk("vec0", got_q[0], 8'h00);
         chk("vec1", got_q[1], 8'h00);
         chk("vec2", got_q[2], 8'h00);
         chk("vec3", got_q[3], 8'hFF);
         chk("vec_consecutive", got_cyc[3] - got_cyc[0], 3);
      end

      // key_sync resynchronises mid-rotation.
      got_q.delete(); got_cyc.delete();
      send(8'h11, 1'b1);
      send(8'h22, 1'b0);
      send(8'hA5, 1'b1);
      send(8'h3C, 1'b0);
      en = 1'b0;
      repeat (5) @(posedge clk); #1;
      chk("sync_count", got_q.size(), 4);
      if (got_q.size() == 4) begin
         chk("sync_a5", got_q[2], 8'h00);
         chk("sync_3c", got_q[3], 8'h00);
      end

      // Round trip through the bench-side encryptor.
      got_q.delete(); got_cyc.delete();
      for (int i = 0; i < 256; i++) send(enc(8'(i), key_of(i % 3)), i == 0);
      en = 1'b0;
      repeat (6) @(posedge clk); #1;
      chk("rt_count", got_q.size(), 256);
      if (got_q.size() == 256) begin
         for (int i = 0; i < 256; i++) chk("rt_byte", got_q[i], i);
         chk("rt_no_gaps", got_cyc[255] - got_cyc[0], 255);
      end

      // Backpressure: consumer stalled while the sender keeps pushing.
      rdy = 1'b0; acc = 0;
      din = 8'($urandom); en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (in_rdy) begin
            acc++;
            @(posedge clk); #1;
            din = 8'($urandom);
         end else begin
            @(posedge clk); #1;
         end
      end
      chk("bp_accepted", acc, DEPTH);
      @(negedge clk);
      chk("bp_in_rdy_low", in_rdy, 0);
      @(posedge clk); #1;
      rdy = 1'b1;
      for (int i = 0; i < 20; i++) send(8'($urandom), 1'b0);
      en = 1'b0;
      repeat (6) @(posedge clk); #1;

      // Random traffic, including key changes when keys are ports.
      for (int i = 0; i < 1500; i++) begin
         en       = ($urandom % 4) != 0;
         din      = 8'($urandom);
         key_sync = ($urandom % 8) == 0;
         rdy      = ($urandom % 3) != 0;
`ifdef DECRYPT_KEY_EN
         if ($urandom % 50 == 0) begin
            k1 = 8'($urandom); k2 = 8'($urandom); k3 = 8'($urandom);
         end
`endif
         @(posedge clk); #1;
      end
      en = 1'b0; key_sync = 1'b0;
`ifdef DECRYPT_KEY_EN
      k1 = 8'h3C; k2 = 8'h77; k3 = 8'hA5;
`endif
      rdy = 1'b1;
      repeat (8) @(posedge clk); #1;

      // Async reset with bytes buffered.
      rdy = 1'b0;
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      en = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("pre_rst_v", v, 1);
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      chk("async_rst_v", v, 0);
      chk("async_rst_in_rdy", in_rdy, 1);
      repeat (2) @(posedge clk); #1;
      rst = 1'b1;
      rdy = 1'b1;
      got_q.delete(); got_cyc.delete();
      send(8'hA5, 1'b0);
      en = 1'b0;
      repeat (5) @(posedge clk); #1;
      chk("post_rst_count", got_q.size(), 1);
      if (got_q.size() == 1) chk("post_rst_phase0", got_q[0], 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/decrypt_unit.md
Name: decrypt_unit

Overview:
- Receive side of the byte cipher: undoes the encrypt_unit transform.
- Per accepted byte: XOR with the current rotating key byte, then apply the inverse of the PERM_0..PERM_7 bit permutation.
- Two-stage pipeline feeding a small output FIFO with valid/ready backpressure.
- Sits between the ciphertext link and the plaintext consumer; key phase resynchronisable via key_sync.

Parameters:
- DEPTH, 4, output FIFO entries. Legal range 2..16. Throughput of 1 byte/clk with rdy held high requires DEPTH >= 3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  8  ciphertext byte.
- en  in  1  din valid. Byte accepted when en && in_rdy.
- key_sync  in  1  sampled only with an accepted byte; forces that byte to use key phase 0.
- in_rdy  out  1  decrypt_unit can accept a byte this cycle.
- dout  out  8  plaintext byte, FIFO head.
- v  out  1  dout valid, FIFO non-empty.
- rdy  in  1  consumer ready. Head popped when v && rdy.

Behaviour:
- Reset (rst=0, async): FIFO empty, v=0, dout=8'h00, in_rdy=1, s1_valid=0, key phase=0. Reset mid-operation discards all in-flight and buffered bytes; no partial output.
- Key schedule matches encrypt_unit. A 2-bit phase counter cycles 0→1→2→0 on each accepted byte.
  - Phase 0 uses XOR_KEY3, phase 1 XOR_KEY1, phase 2 XOR_KEY2.
  - Counter never takes value 3.
- key_sync with accepted byte: that byte uses phase 0; next phase becomes 1.
- key_sync without en (or with en && !in_rdy): ignored.
- Stage 1, edge after acceptance: capture din, the selected key byte and s1_valid=1; advance phase. Without acceptance, s1_valid←0.
- Stage 2, next edge: if s1_valid, compute x = din_s1 ^ key_s1, then plain[PERM_i] = x[i] for i=0..7. Write plain into FIFO tail.
- Latency: byte accepted at edge N appears at dout with v=1 after edge N+1 when the FIFO was empty. Same 2-edge latency as encrypt_unit.
- FIFO: circular buffer with rd_ptr, wr_ptr, count (width clog2(DEPTH+1)).
  - Head is exposed directly: dout=mem[rd_ptr], v=(count!=0). When empty, dout holds its last value.
  - Pop on v && rdy; push and pop in the same cycle leaves count unchanged.
  - Pointers wrap DEPTH-1→0.
- in_rdy = (count + s1_valid) < DEPTH, computed from registers only (no combinational path from rdy or en). This guarantees the stage-1 byte always has a free slot, so overflow is impossible.
- en while in_rdy=0: byte not accepted, phase unchanged. The sender must hold din/en.
- Underflow impossible: pops only qualify with v.
- All output ordering is strictly FIFO.

Optional Feature:
- Macro DECRYPT_KEY_EN.
- Defined: adds input ports k1, k2, k3 (8 bits each) after key_sync. Phase 0/1/2 select k3/k1/k2, sampled at acceptance into stage 1. Changing keys affects only subsequently accepted bytes.
- Undefined: keys are the XOR_KEY1..3 macros from encrypt_config; no extra ports.

Test Plan:
- Reset then idle: rst low 3 clks, release → v=0, dout=8'h00, in_rdy=1; no v pulse over 20 idle clks.
- DECRYPT_KEY_EN, k1=8'h3C, k2=8'h77, k3=8'hA5, rdy=1; send 8'hA5, 8'h3C, 8'h77, 8'h5A on consecutive clks → dout 8'h00, 8'h00, 8'h00, 8'hFF on consecutive clks. First v exactly 2 edges after first acceptance.
- Round trip: encrypt_unit output feeding decrypt_unit, 256 bytes 8'h00..8'hFF, rdy=1 → dout sequence equals input sequence, no gaps after first output.
- Backpressure, DEPTH=4: rdy=0, en=1 continuously → exactly 4 bytes accepted, in_rdy drops. Raise rdy → 4 bytes drain in order, then streaming resumes; no loss or duplication.
- key_sync: after 2 bytes (phase=2), send 8'hA5 with key_sync=1 (DECRYPT_KEY_EN keys as above) → dout 8'h00. Next byte 8'h3C → 8'h00.
- Async reset mid-stream with 3 bytes buffered → v falls immediately. After release, first new byte decrypts with phase 0.
